// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register index / data widths and the writeback entry record.
package cpu_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Producer handshakes, register-file write port and decode hazard/forward query of the writeback queue.
// A request transfers on a rising edge where valid && ready; ready never depends on valid.
interface writeback_queue_if #(parameter int DEPTH = 4);
  import cpu_pkg::*;
  localparam int PTR_W = $clog2(DEPTH);

  logic                 alu_valid;
  logic [REG_IDX_W-1:0] alu_idx;
  logic [XLEN-1:0]      alu_data;
  logic                 alu_ready;

  logic                 mem_valid;
  logic [REG_IDX_W-1:0] mem_idx;
  logic [XLEN-1:0]      mem_data;
  logic                 mem_ready;

  logic [REG_IDX_W-1:0] write_idx;
  logic [XLEN-1:0]      write_data;
  logic                 write_enable;

  logic [REG_IDX_W-1:0] read_idx_1;
  logic [REG_IDX_W-1:0] read_idx_2;
  logic                 hazard_1;
  logic                 hazard_2;
  logic                 fwd_valid_1;
  logic                 fwd_valid_2;
  logic [XLEN-1:0]      fwd_data_1;
  logic [XLEN-1:0]      fwd_data_2;

  logic [PTR_W:0]       count;

  modport master (
    output alu_valid, alu_idx, alu_data, input alu_ready,
    output mem_valid, mem_idx, mem_data, input mem_ready,
    input  write_idx, write_data, write_enable,
    output read_idx_1, read_idx_2,
    input  hazard_1, hazard_2, fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2,
    input  count
  );

  modport slave (
    input  alu_valid, alu_idx, alu_data, output alu_ready,
    input  mem_valid, mem_idx, mem_data, output mem_ready,
    output write_idx, write_data, write_enable,
    input  read_idx_1, read_idx_2,
    output hazard_1, hazard_2, fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2,
    output count
  );
endinterface

// File: rtl/wb_match_search.sv
// Per-read-port search of queued writes: hit if any pending write targets read_idx; with
// WRITEBACK_QUEUE_FORWARD_EN, also returns data of the youngest match (queue before output register).
module wb_match_search
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      entry_valid,
  input  logic [PTR_W-1:0]      head,
  input  wb_entry_t             out_entry,
  input  logic                  out_valid,
  input  logic [REG_IDX_W-1:0]  read_idx,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);
  logic [DEPTH-1:0] entry_hit;
  logic             out_hit;

  always_comb begin
    entry_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_hit[i] = entry_valid[i] && (entries[i].idx == read_idx);
    end
  end

  assign out_hit = out_valid && (out_entry.idx == read_idx);
  assign hit     = (read_idx != REG_ZERO) && (|entry_hit || out_hit);

`ifdef WRITEBACK_QUEUE_FORWARD_EN
  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so the last match seen wins; the output register is older than any entry.
  always_comb begin
    data = '0;
    slot = head;
    if (out_hit) data = out_entry.data;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (entry_hit[slot]) data = entries[slot].data;
    end
    if (!hit) data = '0;
  end
`else
  logic unused_search;
  assign unused_search = ^{head, entries};
  assign data = '0;
`endif
endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue merging ALU and load results into one register-file write port.
// Optional forwarding of pending write data is enabled by defining WRITEBACK_QUEUE_FORWARD_EN.
module writeback_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  writeback_queue_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] MEM_LIMIT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ALU_LIMIT = (PTR_W+1)'(DEPTH - 1);

  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0]      valid_next;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      alu_slot;
  logic [PTR_W:0]        count;
  wb_entry_t             out_entry;
  logic                  out_valid;

  logic mem_fire, alu_fire, mem_store, alu_store, deq;

  // The ALU path stops one slot early so a returning load always has room.
  assign wb.mem_ready = (count < MEM_LIMIT);
  assign wb.alu_ready = (count < ALU_LIMIT);

  assign mem_fire  = wb.mem_valid && wb.mem_ready;
  assign alu_fire  = wb.alu_valid && wb.alu_ready;
  assign mem_store = mem_fire && (wb.mem_idx != REG_ZERO);
  assign alu_store = alu_fire && (wb.alu_idx != REG_ZERO);
  assign deq       = (count != '0);
  assign alu_slot  = tail + PTR_W'(mem_store);

  always_comb begin
    valid_next = entry_valid;
    if (deq)       valid_next[head]     = 1'b0;
    if (mem_store) valid_next[tail]     = 1'b1;
    if (alu_store) valid_next[alu_slot] = 1'b1;
  end

  // Payload storage carries no reset; occupancy is tracked by entry_valid and the pointers.
  always_ff @(posedge clk) begin
    if (mem_store) entries[tail]     <= {wb.mem_idx, wb.mem_data};
    if (alu_store) entries[alu_slot] <= {wb.alu_idx, wb.alu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
      out_entry   <= '0;
      out_valid   <= 1'b0;
    end else begin
      head        <= head + PTR_W'(deq);
      tail        <= tail + PTR_W'(mem_store) + PTR_W'(alu_store);
      count       <= count + (PTR_W+1)'(mem_store) + (PTR_W+1)'(alu_store) - (PTR_W+1)'(deq);
      entry_valid <= valid_next;
      out_valid   <= deq;
      if (deq) out_entry <= entries[head];
    end
  end

  assign wb.write_enable = out_valid;
  assign wb.write_idx    = out_entry.idx;
  assign wb.write_data   = out_entry.data;
  assign wb.count        = count;

  logic            hit_1, hit_2;
  logic [XLEN-1:0] search_data_1, search_data_2;

  wb_match_search #(.DEPTH(DEPTH)) u_search_1 (
    .entries     (entries),
    .entry_valid (entry_valid),
    .head        (head),
    .out_entry   (out_entry),
    .out_valid   (out_valid),
    .read_idx    (wb.read_idx_1),
    .hit         (hit_1),
    .data        (search_data_1)
  );

  wb_match_search #(.DEPTH(DEPTH)) u_search_2 (
    .entries     (entries),
    .entry_valid (entry_valid),
    .head        (head),
    .out_entry   (out_entry),
    .out_valid   (out_valid),
    .read_idx    (wb.read_idx_2),
    .hit         (hit_2),
    .data        (search_data_2)
  );

  assign wb.hazard_1 = hit_1;
  assign wb.hazard_2 = hit_2;

`ifdef WRITEBACK_QUEUE_FORWARD_EN
  assign wb.fwd_valid_1 = hit_1;
  assign wb.fwd_valid_2 = hit_2;
  assign wb.fwd_data_1  = search_data_1;
  assign wb.fwd_data_2  = search_data_2;
`else
  logic unused_fwd;
  assign unused_fwd     = ^{search_data_1, search_data_2};
  assign wb.fwd_valid_1 = 1'b0;
  assign wb.fwd_valid_2 = 1'b0;
  assign wb.fwd_data_1  = '0;
  assign wb.fwd_data_2  = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, latency, ordering, x0 filtering, back-pressure, forwarding.
module tb_writeback_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [36:0] exp_q[$];

  writeback_queue_if #(.DEPTH(DEPTH)) wb ();

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0;
    wb.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (wb.count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", wb.count); end
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", wb.write_enable); end
    checks++; if ({wb.write_idx, wb.write_data} !== 37'd0) begin failures++; $display("FAIL reset_wport: got %h/%h expected 0/0", wb.write_idx, wb.write_data); end
    checks++; if ({wb.alu_ready, wb.mem_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready: got %b%b expected 11", wb.alu_ready, wb.mem_ready); end
    checks++; if ({wb.hazard_1, wb.hazard_2, wb.fwd_valid_1, wb.fwd_valid_2} !== 4'b0000) begin failures++; $display("FAIL reset_hazard: got %b%b%b%b expected 0000", wb.hazard_1, wb.hazard_2, wb.fwd_valid_1, wb.fwd_valid_2); end
  endtask

  task automatic test_single_alu();
    wb.read_idx_1 = 5'd5;
    wb.alu_valid  = 1'b1;
    wb.alu_idx    = 5'd5;
    wb.alu_data   = 32'hDEADBEEF;
    checks++; if (wb.alu_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", wb.alu_ready); end
    step();
    idle();
    checks++; if (wb.count !== 3'd1) begin failures++; $display("FAIL single_count_n: got %0d expected 1", wb.count); end
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL single_we_n: got %b expected 0", wb.write_enable); end
    checks++; if (wb.hazard_1 !== 1'b1) begin failures++; $display("FAIL single_hazard_n: got %b expected 1", wb.hazard_1); end
    step();
    checks++; if (wb.write_enable !== 1'b1) begin failures++; $display("FAIL single_we_n1: got %b expected 1", wb.write_enable); end
    checks++; if ({wb.write_idx, wb.write_data} !== {5'd5, 32'hDEADBEEF}) begin failures++; $display("FAIL single_wport: got %0d/%h expected 5/deadbeef", wb.write_idx, wb.write_data); end
    checks++; if (wb.hazard_1 !== 1'b1) begin failures++; $display("FAIL single_hazard_n1: got %b expected 1", wb.hazard_1); end
    checks++; if (wb.count !== 3'd0) begin failures++; $display("FAIL single_count_n1: got %0d expected 0", wb.count); end
    step();
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL single_we_n2: got %b expected 0", wb.write_enable); end
    checks++; if (wb.hazard_1 !== 1'b0) begin failures++; $display("FAIL single_hazard_n2: got %b expected 0", wb.hazard_1); end
    checks++; if (wb.write_idx !== 5'd5) begin failures++; $display("FAIL single_hold_idx: got %0d expected 5", wb.write_idx); end
    wb.read_idx_1 = 5'd0;
  endtask

  task automatic test_simultaneous();
    wb.mem_valid = 1'b1; wb.mem_idx = 5'd3; wb.mem_data = 32'h11;
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd4; wb.alu_data = 32'h22;
    step();
    idle();
    checks++; if (wb.count !== 3'd2) begin failures++; $display("FAIL simul_count: got %0d expected 2", wb.count); end
    step();
    checks++; if ({wb.write_enable, wb.write_idx, wb.write_data} !== {1'b1, 5'd3, 32'h11}) begin failures++; $display("FAIL simul_first: got %b/%0d/%h expected 1/3/11", wb.write_enable, wb.write_idx, wb.write_data); end
    step();
    checks++; if ({wb.write_enable, wb.write_idx, wb.write_data} !== {1'b1, 5'd4, 32'h22}) begin failures++; $display("FAIL simul_second: got %b/%0d/%h expected 1/4/22", wb.write_enable, wb.write_idx, wb.write_data); end
    step();
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL simul_empty_we: got %b expected 0", wb.write_enable); end
  endtask

  task automatic test_x0();
    wb.read_idx_1 = 5'd0;
    wb.alu_valid  = 1'b1;
    wb.alu_idx    = 5'd0;
    wb.alu_data   = 32'hFFFF;
    checks++; if (wb.alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready: got %b expected 1", wb.alu_ready); end
    step();
    idle();
    checks++; if (wb.count !== 3'd0) begin failures++; $display("FAIL x0_count: got %0d expected 0", wb.count); end
    checks++; if (wb.hazard_1 !== 1'b0) begin failures++; $display("FAIL x0_hazard: got %b expected 0", wb.hazard_1); end
    step();
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL x0_we: got %b expected 0", wb.write_enable); end
  endtask

  task automatic test_reset_mid();
    wb.mem_valid = 1'b1; wb.mem_idx = 5'd10; wb.mem_data = 32'h100;
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd11; wb.alu_data = 32'h101;
    step();
    wb.mem_idx = 5'd12; wb.mem_data = 32'h102;
    wb.alu_idx = 5'd13; wb.alu_data = 32'h103;
    step();
    idle();
    wb.read_idx_1 = 5'd12;
    wb.read_idx_2 = 5'd13;
    #1;
    checks++; if (wb.count !== 3'd3) begin failures++; $display("FAIL mid_fill_count: got %0d expected 3", wb.count); end
    checks++; if ({wb.hazard_1, wb.hazard_2} !== 2'b11) begin failures++; $display("FAIL mid_fill_hazard: got %b%b expected 11", wb.hazard_1, wb.hazard_2); end
    rst_n = 1'b0;
    #1;
    checks++; if (wb.count !== 3'd0) begin failures++; $display("FAIL mid_rst_count: got %0d expected 0", wb.count); end
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_we: got %b expected 0", wb.write_enable); end
    checks++; if ({wb.hazard_1, wb.hazard_2} !== 2'b00) begin failures++; $display("FAIL mid_rst_hazard: got %b%b expected 00", wb.hazard_1, wb.hazard_2); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({wb.write_enable, wb.count} !== 4'b0_000) begin failures++; $display("FAIL mid_after_rst: got we=%b count=%0d expected 0/0", wb.write_enable, wb.count); end
    wb.read_idx_1 = 5'd0;
    wb.read_idx_2 = 5'd0;
  endtask

  task automatic test_back_pressure();
    int          m_count = 0;
    logic        m_we    = 1'b0;
    logic [36:0] m_out   = '0;
    int          m_seq   = 0;
    int          a_seq   = 0;
    logic        mf, af, drive;
    logic [36:0] m_pay, a_pay;
    exp_q.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      checks++; if (wb.count !== (PTR_W+1)'(m_count)) begin failures++; $display("FAIL bp_count[%0d]: got %0d expected %0d", cyc, wb.count, m_count); end
      checks++; if (wb.alu_ready !== (m_count < DEPTH - 1)) begin failures++; $display("FAIL bp_alu_ready[%0d]: got %b count %0d", cyc, wb.alu_ready, m_count); end
      checks++; if (wb.mem_ready !== (m_count < DEPTH)) begin failures++; $display("FAIL bp_mem_ready[%0d]: got %b count %0d", cyc, wb.mem_ready, m_count); end
      checks++; if (wb.write_enable !== m_we) begin failures++; $display("FAIL bp_we[%0d]: got %b expected %b", cyc, wb.write_enable, m_we); end
      if (m_we) begin
        checks++; if ({wb.write_idx, wb.write_data} !== m_out) begin failures++; $display("FAIL bp_order[%0d]: got %0d/%h expected %0d/%h", cyc, wb.write_idx, wb.write_data, m_out[36:32], m_out[31:0]); end
      end
      drive = (cyc < 8);
      m_pay = {5'(16 + (m_seq % 8)), 32'h1000 + 32'(m_seq)};
      a_pay = {5'(24 + (a_seq % 8)), 32'h2000 + 32'(a_seq)};
      wb.mem_valid = drive; wb.mem_idx = m_pay[36:32]; wb.mem_data = m_pay[31:0];
      wb.alu_valid = drive; wb.alu_idx = a_pay[36:32]; wb.alu_data = a_pay[31:0];
      mf = drive && (m_count < DEPTH);
      af = drive && (m_count < DEPTH - 1);
      @(posedge clk);
      if (m_count > 0) begin m_out = exp_q.pop_front(); m_we = 1'b1; end
      else m_we = 1'b0;
      if (mf) begin exp_q.push_back(m_pay); m_seq++; end
      if (af) begin exp_q.push_back(a_pay); a_seq++; end
      m_count = exp_q.size();
      #1;
    end
    idle();
    checks++; if (wb.count !== 3'd0 || m_count != 0) begin failures++; $display("FAIL bp_final_count: got %0d model %0d expected 0", wb.count, m_count); end
  endtask

  task automatic test_forward();
    wb.read_idx_2 = 5'd7;
    wb.mem_valid = 1'b1; wb.mem_idx = 5'd7; wb.mem_data = 32'hA;
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd7; wb.alu_data = 32'hB;
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      checks++; if (wb.hazard_2 !== 1'b1) begin failures++; $display("FAIL fwd_hazard[%0d]: got %b expected 1", c, wb.hazard_2); end
`ifdef WRITEBACK_QUEUE_FORWARD_EN
      checks++; if ({wb.fwd_valid_2, wb.fwd_data_2} !== {1'b1, 32'hB}) begin failures++; $display("FAIL fwd_data[%0d]: got %b/%h expected 1/b", c, wb.fwd_valid_2, wb.fwd_data_2); end
`else
      checks++; if ({wb.fwd_valid_2, wb.fwd_data_2} !== 33'd0) begin failures++; $display("FAIL fwd_tied[%0d]: got %b/%h expected 0/0", c, wb.fwd_valid_2, wb.fwd_data_2); end
`endif
      if (c == 1) begin
        checks++; if ({wb.write_enable, wb.write_data} !== {1'b1, 32'hA}) begin failures++; $display("FAIL fwd_order: got %b/%h expected 1/a", wb.write_enable, wb.write_data); end
      end
      step();
    end
    checks++; if (wb.hazard_2 !== 1'b0) begin failures++; $display("FAIL fwd_drained: got %b expected 0", wb.hazard_2); end
    wb.read_idx_2 = 5'd0;
  endtask

  // Test sequence and final report
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wb.alu_valid = 1'b0; wb.alu_idx = '0; wb.alu_data = '0;
    wb.mem_valid = 1'b0; wb.mem_idx = '0; wb.mem_data = '0;
    wb.read_idx_1 = '0;  wb.read_idx_2 = '0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    test_reset();
    step();
    test_single_alu();
    repeat (2) step();
    test_simultaneous();
    repeat (2) step();
    test_x0();
    repeat (2) step();
    test_reset_mid();
    repeat (2) step();
    test_back_pressure();
    repeat (2) step();
    test_forward();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
